// File: rtl/rf_wport_arbiter_pkg.sv
// Shared register-file write-port types.
// Used by the write-port arbiter and reusable by WB/MEM.
package rf_wport_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_WE_W   = 4;

    localparam logic [RF_WE_W-1:0] RF_WE_ALL  = '1;
    localparam logic [RF_WE_W-1:0] RF_WE_NONE = '0;

    typedef struct packed {
        logic [RF_WE_W-1:0]   we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wreq_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } ll_entry_t;

endpackage

// File: rtl/rf_wport_arbiter_wfifo.sv
// Small synchronous FIFO holding long-latency results
// until the register-file write port is free.
module rf_wfifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  ll_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output ll_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ll_entry_t     mem_q [DEPTH];
    ll_entry_t     mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the regfile write port between WB and long-latency
// writeback, with starvation guard and busy scoreboard for ID.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RF_WE_W-1:0]   wb_we,
    input  logic [RF_ADDR_W-1:0] wb_waddr,
    input  logic [RF_DATA_W-1:0] wb_wdata,
    input  logic                 ll_valid,
    input  logic [RF_ADDR_W-1:0] ll_waddr,
    input  logic [RF_DATA_W-1:0] ll_wdata,
    output logic                 ll_ready,
    input  logic                 iss_valid,
    input  logic [RF_ADDR_W-1:0] iss_rd,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic [RF_ADDR_W-1:0] id_rd,
    output logic                 id_sb_stall,
    output logic                 wb_hold,
    output logic [RF_WE_W-1:0]   rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata,
    output logic [31:0]          busy_vec
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          wb_act;
    ll_entry_t     head;
    ll_entry_t     push_data;
    rf_wreq_t      grant;
    logic [SW-1:0] starve_q, starve_d;
    logic          wb_hold_q, wb_hold_d;
    logic [31:0]   busy_q, busy_d;

    rf_wfifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_comb begin
        wb_act    = |wb_we;
        push      = ll_valid && !full;
        push_data = '{addr: ll_waddr, data: ll_wdata};
        pop       = !reset && !wb_act && !empty;
        grant     = '{we: RF_WE_NONE, addr: '0, data: '0};
        // Reset outranks both sources so no write leaks out mid-reset.
        priority case (1'b1)
            reset:  grant = '{we: RF_WE_NONE, addr: '0, data: '0};
            wb_act: grant = '{we: wb_we, addr: wb_waddr, data: wb_wdata};
            !empty: grant = '{we: RF_WE_ALL, addr: head.addr, data: head.data};
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
        wb_hold_d = !empty && !pop && (starve_d >= SW'(STARVE_LIMIT - 1));
    end

    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.addr] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= '0;
            wb_hold_q <= 1'b0;
            busy_q    <= '0;
        end else begin
            starve_q  <= starve_d;
            wb_hold_q <= wb_hold_d;
            busy_q    <= busy_d;
        end
    end

    assign ll_ready    = !full;
    assign wb_hold     = wb_hold_q;
    assign busy_vec    = busy_q;
    assign rf_we       = grant.we;
    assign rf_waddr    = grant.addr;
    assign rf_wdata    = grant.data;
    assign id_sb_stall = ((id_rs1 != '0) && busy_q[id_rs1])
                      || ((id_rs2 != '0) && busy_q[id_rs2])
                      || ((id_rd  != '0) && busy_q[id_rd]);

    a_no_wb_during_hold: assert property (
        @(posedge clk) disable iff (reset) !(wb_hold_q && (|wb_we))
    );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios
// followed by randomized traffic against a queue-based model.
module tb_rf_wport_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ll_valid;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_sb_stall;
    logic        wb_hold;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending results in arrival order, busy set,
    // and how many cycles the current head has been kept waiting.
    logic [36:0] mq[$];
    logic [31:0] m_busy;
    int          m_age;
    bit          m_hold;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ll_valid(ll_valid), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
        .ll_ready(ll_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_sb_stall(id_sb_stall), .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec)
    );

    task automatic model_edge();
        int          n;
        bit          popped;
        logic [36:0] h;
        if (reset) begin
            mq.delete();
            m_busy = '0;
            m_age  = 0;
            m_hold = 0;
        end else begin
            n      = mq.size();
            popped = (wb_we == 4'h0) && (n > 0);
            if (n == 0 || popped) begin
                m_age  = 0;
                m_hold = 0;
            end else begin
                if (m_age < STARVE_LIMIT) m_age = m_age + 1;
                m_hold = (m_age >= STARVE_LIMIT - 1);
            end
            if (popped) begin
                h = mq.pop_front();
                m_busy[h[36:32]] = 1'b0;
            end
            if (iss_valid) m_busy[iss_rd] = 1'b1;
            m_busy[0] = 1'b0;
            if (ll_valid && n < DEPTH) mq.push_back({ll_waddr, ll_wdata});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 4'h0; wb_waddr = '0; wb_wdata = '0;
        ll_valid = 0; ll_waddr = '0; ll_wdata = '0;
        iss_valid = 0; iss_rd = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'h0) begin
            failures++;
            $display("FAIL reset_rf_we: got %h want 0", rf_we);
        end
        checks++;
        if (ll_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ll_ready: got %b want 1", ll_ready);
        end
        checks++;
        if (busy_vec !== 32'h0 || wb_hold !== 1'b0 || id_sb_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%h hold=%b stall=%b want 0/0/0",
                     busy_vec, wb_hold, id_sb_stall);
        end
        tick();
    endtask

    task automatic test_ll_commit();
        iss_valid = 1; iss_rd = 5;
        tick();
        iss_valid = 0; id_rs1 = 5;
        @(negedge clk);
        checks++;
        if (busy_vec[5] !== 1'b1 || id_sb_stall !== 1'b1) begin
            failures++;
            $display("FAIL commit_busy_set: busy5=%b stall=%b want 1/1",
                     busy_vec[5], id_sb_stall);
        end
        tick();
        tick();
        ll_valid = 1; ll_waddr = 5; ll_wdata = 32'h1234;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'h0) begin
            failures++;
            $display("FAIL commit_no_bypass: got %h want 0", rf_we);
        end
        tick();
        ll_valid = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            failures++;
            $display("FAIL commit_write: got %h/%0d/%h want F/5/00001234",
                     rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (id_sb_stall !== 1'b1 || busy_vec[5] !== 1'b1) begin
            failures++;
            $display("FAIL commit_stall_hold: stall=%b busy5=%b want 1/1",
                     id_sb_stall, busy_vec[5]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (id_sb_stall !== 1'b0 || busy_vec[5] !== 1'b0 || rf_we !== 4'h0) begin
            failures++;
            $display("FAIL commit_release: stall=%b busy5=%b we=%h want 0/0/0",
                     id_sb_stall, busy_vec[5], rf_we);
        end
        id_rs1 = 0;
        tick();
    endtask

    task automatic test_starve();
        ll_valid = 1; ll_waddr = 12; ll_wdata = 32'hCAFE_0012;
        wb_we = 4'hF; wb_waddr = 7; wb_wdata = 32'h7000_0000;
        tick();
        ll_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            wb_wdata = 32'h7000_0000 + c;
            @(negedge clk);
            checks++;
            if (rf_we !== 4'hF || rf_waddr !== 5'd7 || wb_hold !== 1'b0) begin
                failures++;
                $display("FAIL starve_wb_wins c%0d: we=%h addr=%0d hold=%b want F/7/0",
                         c, rf_we, rf_waddr, wb_hold);
            end
            tick();
        end
        checks++;
        if (wb_hold !== 1'b1) begin
            failures++;
            $display("FAIL starve_hold: got %b want 1", wb_hold);
        end
        wb_we = 4'h0;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd12 || rf_wdata !== 32'hCAFE_0012) begin
            failures++;
            $display("FAIL starve_commit: got %h/%0d/%h want F/12/cafe0012",
                     rf_we, rf_waddr, rf_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (wb_hold !== 1'b0 || rf_we !== 4'h0) begin
            failures++;
            $display("FAIL starve_release: hold=%b we=%h want 0/0", wb_hold, rf_we);
        end
        tick();
    endtask

    task automatic test_full();
        logic [31:0] exp_d[3];
        exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hA3;
        wb_we = 4'hF; wb_waddr = 20;
        for (int k = 0; k < 2; k++) begin
            ll_valid = 1; ll_waddr = 5'(k + 1); ll_wdata = exp_d[k];
            @(negedge clk);
            checks++;
            if (ll_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_accept%0d: ll_ready=%b want 1", k, ll_ready);
            end
            tick();
        end
        ll_waddr = 3; ll_wdata = exp_d[2];
        @(negedge clk);
        checks++;
        if (ll_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: got %b want 0", ll_ready);
        end
        tick();
        wb_we = 4'h0;
        @(negedge clk);
        checks++;
        if (ll_ready !== 1'b0 || rf_waddr !== 5'd1 || rf_wdata !== exp_d[0]) begin
            failures++;
            $display("FAIL full_pop_no_push: ready=%b addr=%0d data=%h want 0/1/a1",
                     ll_ready, rf_waddr, rf_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ll_ready !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== exp_d[1]) begin
            failures++;
            $display("FAIL full_order2: ready=%b addr=%0d data=%h want 1/2/a2",
                     ll_ready, rf_waddr, rf_wdata);
        end
        tick();
        ll_valid = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd3 || rf_wdata !== exp_d[2]) begin
            failures++;
            $display("FAIL full_order3: we=%h addr=%0d data=%h want F/3/a3",
                     rf_we, rf_waddr, rf_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rf_we !== 4'h0) begin
            failures++;
            $display("FAIL full_drained: got %h want 0", rf_we);
        end
        tick();
    endtask

    task automatic test_set_clear_same();
        iss_valid = 1; iss_rd = 9;
        tick();
        iss_valid = 0;
        ll_valid = 1; ll_waddr = 9; ll_wdata = 32'h9999;
        tick();
        ll_valid = 0;
        iss_valid = 1; iss_rd = 9;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd9) begin
            failures++;
            $display("FAIL same_commit: we=%h addr=%0d want F/9", rf_we, rf_waddr);
        end
        tick();
        iss_valid = 0;
        @(negedge clk);
        checks++;
        if (busy_vec[9] !== 1'b1) begin
            failures++;
            $display("FAIL same_set_wins: busy9=%b want 1", busy_vec[9]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_valid = 0;
        wb_we = 4'hF; wb_waddr = 1;
        ll_valid = 1;
        for (int k = 0; k < 2; k++) begin
            ll_waddr = 5'(k + 3); ll_wdata = 32'hB0 + k;
            tick();
        end
        ll_valid = 0;
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0000_0208 || ll_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: busy=%h ready=%b want 00000208/0",
                     busy_vec, ll_ready);
        end
        reset = 1; wb_we = 4'h0;
        @(negedge clk);
        checks++;
        if (rf_we !== 4'h0) begin
            failures++;
            $display("FAIL rstmid_no_write: got %h want 0", rf_we);
        end
        tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if (busy_vec !== 32'h0 || ll_ready !== 1'b1 || rf_we !== 4'h0 || wb_hold !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_post: busy=%h ready=%b we=%h hold=%b want 0/1/0/0",
                     busy_vec, ll_ready, rf_we, wb_hold);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            wb_we     = (m_hold || $urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wb_waddr  = 5'($urandom);
            wb_wdata  = $urandom;
            ll_valid  = $urandom_range(0, 1);
            ll_waddr  = 5'($urandom);
            ll_wdata  = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom);
            id_rs1    = 5'($urandom);
            id_rs2    = 5'($urandom);
            id_rd     = 5'($urandom);
            e_we = 4'h0; e_addr = '0; e_data = '0;
            if (reset) e_we = 4'h0;
            else if (wb_we != 4'h0) begin
                e_we = wb_we; e_addr = wb_waddr; e_data = wb_wdata;
            end else if (mq.size() > 0) begin
                e_we = 4'hF; e_addr = mq[0][36:32]; e_data = mq[0][31:0];
            end
            e_stall = (id_rs1 != 0 && m_busy[id_rs1]) || (id_rs2 != 0 && m_busy[id_rs2])
                   || (id_rd != 0 && m_busy[id_rd]);
            @(negedge clk);
            checks++;
            if (rf_we !== e_we || (e_we != 4'h0 && (rf_waddr !== e_addr || rf_wdata !== e_data))) begin
                failures++;
                $display("FAIL rnd_rf c%0d: got %h/%0d/%h want %h/%0d/%h",
                         c, rf_we, rf_waddr, rf_wdata, e_we, e_addr, e_data);
            end
            checks++;
            if (ll_ready !== (mq.size() < DEPTH) || wb_hold !== m_hold) begin
                failures++;
                $display("FAIL rnd_flow c%0d: ready=%b hold=%b want %b/%b",
                         c, ll_ready, wb_hold, mq.size() < DEPTH, m_hold);
            end
            checks++;
            if (busy_vec !== m_busy || id_sb_stall !== e_stall) begin
                failures++;
                $display("FAIL rnd_sb c%0d: busy=%h stall=%b want %h/%b",
                         c, busy_vec, id_sb_stall, m_busy, e_stall);
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        mq.delete();
        m_busy = '0;
        m_age  = 0;
        m_hold = 0;
        test_reset();
        test_ll_commit();
        test_starve();
        test_full();
        test_set_clear_same();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the in-order WB stage and the long-latency unit (divider/multiplier) writeback.
- Buffers long-latency results in a small FIFO. WB gets priority; a starvation guard forces a WB bubble when needed.
- Keeps a per-register busy scoreboard so ID stalls on RAW/WAW against outstanding long-latency ops.
- Sits between WB_stage outputs and the regfile write port; ID and EX consult it.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before wb_hold asserts

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wb_we  in  4  WB byte write enables, already gated by wb_valid
- wb_waddr  in  5  WB destination register
- wb_wdata  in  32  WB write data
- ll_valid  in  1  long-latency result offered
- ll_waddr  in  5  long-latency destination
- ll_wdata  in  32  long-latency result
- ll_ready  out  1  FIFO can accept (= !full)
- iss_valid  in  1  EX issues a long-latency op this cycle
- iss_rd  in  5  its destination
- id_rs1  in  5  ID source 1 (0 = unused)
- id_rs2  in  5  ID source 2 (0 = unused)
- id_rd  in  5  ID destination (0 = none)
- id_sb_stall  out  1  any nonzero id_rs1/id_rs2/id_rd is busy
- wb_hold  out  1  registered; pipeline must present wb_we=0 next cycle
- rf_we  out  4  regfile byte enables
- rf_waddr  out  5  regfile address
- rf_wdata  out  32  regfile data
- busy_vec  out  32  scoreboard (debug)

Behaviour:
- Reset: FIFO empty, busy_vec=0, starve counter=0, wb_hold=0. ll_ready=1. rf_we=0. id_sb_stall=0.
- Accept: ll_valid && ll_ready pushes {waddr,wdata} at the clock edge. Earliest commit is the next cycle; there is no same-cycle bypass to RF.
- Grant, combinational:
  - If wb_we!=0, the RF port carries WB.
  - Otherwise, if the FIFO is non-empty, the RF port carries the head with rf_we=4'hF and the head pops at the edge.
  - Otherwise rf_we=0.
- Full FIFO with simultaneous pop: ll_ready stays 0 that cycle (no push-on-pop-when-full).
- Pointers wrap modulo DEPTH. An occupancy counter of width clog2(DEPTH)+1 distinguishes full from empty.
- Starve counter:
  - Resets to 0 on any head pop or while the FIFO is empty.
  - Increments while the FIFO is non-empty and not popped, saturating at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT-1 and the head is still not popped, wb_hold=1 next cycle.
  - wb_hold deasserts the cycle after the pop.
  - If wb_we!=0 arrives while wb_hold=1 (protocol violation), WB still wins; a sim-only assertion flags it.
- Scoreboard:
  - iss_valid sets busy[iss_rd]. Commit of the FIFO head clears busy[head.waddr].
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is never set.
  - WB-side writes do not touch the scoreboard.
- id_sb_stall is combinational from busy_vec (registered state). It does not include same-cycle iss_valid; EX→ID ordering guarantees ID sees the set one cycle later. It does not clear early on the commit cycle.
- Invariant: at most one outstanding op per register, guaranteed by the id_rd check. The number outstanding is ≤ DEPTH plus unit capacity. The unit respects ll_ready.
- Reset mid-operation discards FIFO contents and busy bits. No RF write occurs in the reset cycle.

Decomposition:
- Shared package: RF_ADDR_W=5, RF_DATA_W=32, RF_WE_W=4, and a struct-like constant group for a write request {we,addr,data}. This is reusable by WB/MEM.
- One natural sub-module: rf_wfifo, a DEPTH-entry synchronous FIFO with push/pop/full/empty/head. The arbiter instantiates it and holds the grant, starve and scoreboard logic.

Test Plan:
- Reset then idle → rf_we=0, ll_ready=1, busy_vec=0, wb_hold=0.
- iss_valid rd=5; 3 cycles later ll_valid waddr=5 wdata=0x1234 with wb_we=0 → push, commit next cycle with rf_we=F/addr=5/data=0x1234; busy[5] goes 1→0; ID rs1=5 stalls until the cycle after commit.
- WB writes every cycle (wb_we=F, addr=7) with one FIFO entry pending → WB wins for 3 cycles; wb_hold=1 in cycle 4; bench drives wb_we=0; FIFO commits; wb_hold drops next cycle.
- Two ll pushes while WB is busy (DEPTH=2) → ll_ready=0; third ll_valid is held; after pops, data commits in FIFO order with no loss.
- iss_valid rd=9 and commit of rd=9 in the same cycle → busy[9] remains 1.
- Reset asserted with 2 FIFO entries and busy[3,9]=1 → next cycle empty, busy_vec=0, no rf_we pulse.
